// File: rtl/ans_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ans_decoder_pkg
// Shared constants and FSM state encoding for the streaming rANS decoder.
//   SYM_WIDTH    width of a stream word and of a decoded symbol
//   CNT_WIDTH    width of a symbol count
//   STATE_WIDTH  coder state width (multiple of SYM_WIDTH)
//   NSYM_WIDTH   width of the frame-length input
//   INIT_WORDS   stream words needed to load the initial coder state
// ---------------------------------------------------------------------------
package ans_decoder_pkg;

  localparam int SYM_WIDTH   = 8;
  localparam int CNT_WIDTH   = 8;
  localparam int STATE_WIDTH = 16;
  localparam int NSYM_WIDTH  = 16;
  localparam int INIT_WORDS  = STATE_WIDTH / SYM_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    CHECK  = 3'd2,
    LOOKUP = 3'd3,
    EMIT   = 3'd4,
    RENORM = 3'd5,
    DONE   = 3'd6
  } dec_state_t;

endpackage

// File: rtl/ans_decoder_update.sv
// ---------------------------------------------------------------------------
// ans_dec_update
// Combinational rANS state update:
//   x_next = count * (x >> total_log2) + slot - cum
// The product is formed at STATE_W+CNT_W bits and the result truncated to
// STATE_W. Kept separate so an interleaved decoder can reuse it.
// Ports:
//   x           in   STATE_W  current coder state
//   total_log2  in   5        log2 of the table total
//   count       in   CNT_W    count of the decoded symbol
//   slot        in   SLOT_W   slot that selected the symbol
//   cum         in   SLOT_W   cumulative count of the decoded symbol
//   x_next      out  STATE_W  updated coder state
// ---------------------------------------------------------------------------
module ans_dec_update #(
  parameter int STATE_W = 16,
  parameter int CNT_W   = 8,
  parameter int SLOT_W  = 16
) (
  input  logic [STATE_W-1:0] x,
  input  logic [4:0]         total_log2,
  input  logic [CNT_W-1:0]   count,
  input  logic [SLOT_W-1:0]  slot,
  input  logic [SLOT_W-1:0]  cum,
  output logic [STATE_W-1:0] x_next
);

  localparam int PW = STATE_W + CNT_W;

  // Wrap-around arithmetic is intended: a corrupt table (count==0 or
  // slot<cum) just yields a garbage state, never a stall.
  assign x_next = STATE_W'(PW'(count) * PW'(x >> total_log2) + PW'(slot) - PW'(cum));

endmodule

// File: rtl/ans_decoder.sv
// ---------------------------------------------------------------------------
// ans_decoder
// Streaming rANS decoder. Loads the initial coder state from the word
// stream, then per symbol: slot lookup through the external table port,
// state update, symbol emit, renormalise by pulling words.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ena               clock enable; all state holds when low
//   start             begin a frame (accepted in IDLE or DONE)
//   num_syms          symbols in the frame
//   total_log2        log2 of the table total M
//   in/in_vld/in_rdy  stream word input handshake
//   lut_slot          registered slot = x & (M-1) presented to the table
//   lut_sym/count/cum table answer for lut_slot (combinational)
//   out/out_vld/out_rdy  decoded symbol output handshake
//   done              frame complete (level, until next start)
//   err               final state != M+1, valid while done
// ---------------------------------------------------------------------------
module ans_decoder
  import ans_decoder_pkg::*;
#(
  parameter int SYM_W   = SYM_WIDTH,
  parameter int CNT_W   = CNT_WIDTH,
  parameter int STATE_W = STATE_WIDTH,
  parameter int NSYM_W  = NSYM_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic [NSYM_W-1:0]      num_syms,
  input  logic [4:0]             total_log2,
  input  logic [SYM_W-1:0]       in,
  input  logic                   in_vld,
  output logic                   in_rdy,
  output logic [SYM_W+CNT_W-1:0] lut_slot,
  input  logic [SYM_W-1:0]       lut_sym,
  input  logic [CNT_W-1:0]       lut_count,
  input  logic [SYM_W+CNT_W-1:0] lut_cum,
  output logic [SYM_W-1:0]       out,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   done,
  output logic                   err
);

  localparam int SLOT_W = SYM_W + CNT_W;
  localparam int N_INIT = STATE_W / SYM_W;
  localparam int WC_W   = $clog2(N_INIT + 1);
  // Wide enough to hold M = 1<<31 and M+1 next to the state and slot.
  localparam int WIDE_W = ((STATE_W > SLOT_W) ? STATE_W : SLOT_W) + 33;

  dec_state_t          state_q, state_d;
  logic [STATE_W-1:0]  x_q;
  logic [WC_W-1:0]     words_left_q;
  logic [NSYM_W-1:0]   remaining_q;
  logic [4:0]          tl2_q;

  logic [WIDE_W-1:0]   m_wide;
  logic [WIDE_W-1:0]   x_wide;
  logic [STATE_W-1:0]  x_shift;
  logic [STATE_W-1:0]  x_upd;
  logic                x_below_m;
  logic                shift_below_m;
  logic                start_ok;

  assign m_wide        = WIDE_W'(1) << tl2_q;
  assign x_wide        = WIDE_W'(x_q);
  assign x_shift       = (x_q << SYM_W) | STATE_W'(in);
  assign x_below_m     = x_wide < m_wide;
  assign shift_below_m = WIDE_W'(x_shift) < m_wide;
  assign start_ok      = start && ((state_q == IDLE) || (state_q == DONE));
  assign in_rdy        = (state_q == INIT) || (state_q == RENORM);

  ans_dec_update #(
    .STATE_W (STATE_W),
    .CNT_W   (CNT_W),
    .SLOT_W  (SLOT_W)
  ) u_update (
    .x          (x_q),
    .total_log2 (tl2_q),
    .count      (lut_count),
    .slot       (lut_slot),
    .cum        (lut_cum),
    .x_next     (x_upd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // EMIT and each renorm word jump straight to CHECK once x >= M, so a
  // symbol costs three cycles plus one per pulled word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = INIT;
      INIT:    if (in_vld && (words_left_q == WC_W'(1))) state_d = CHECK;
      CHECK:   state_d = (remaining_q == '0) ? DONE : LOOKUP;
      LOOKUP:  state_d = EMIT;
      EMIT:    if (out_rdy) state_d = x_below_m ? RENORM : CHECK;
      RENORM:  if (in_vld && !shift_below_m) state_d = CHECK;
      DONE:    if (start_ok) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      words_left_q <= '0;
      remaining_q  <= '0;
      tl2_q        <= '0;
      lut_slot     <= '0;
      out          <= '0;
      out_vld      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            words_left_q <= WC_W'(N_INIT);
            remaining_q  <= num_syms;
            tl2_q        <= total_log2;
            done         <= 1'b0;
            err          <= 1'b0;
          end
        end
        INIT: begin
          if (in_vld) begin
            x_q          <= x_shift;
            words_left_q <= words_left_q - WC_W'(1);
          end
        end
        CHECK: begin
          if (remaining_q == '0) begin
            done <= 1'b1;
            err  <= (x_wide != (m_wide + WIDE_W'(1)));
          end else begin
            lut_slot <= SLOT_W'(x_wide & (m_wide - WIDE_W'(1)));
          end
        end
        LOOKUP: begin
          x_q     <= x_upd;
          out     <= lut_sym;
          out_vld <= 1'b1;
        end
        EMIT: begin
          if (out_rdy) begin
            out_vld     <= 1'b0;
            remaining_q <= remaining_q - NSYM_W'(1);
          end
        end
        RENORM: begin
          if (in_vld) x_q <= x_shift;
        end
        default: ;
      endcase
    end
  end

endmodule
